// File: rtl/btb_pkg.sv
// Shared types and helpers for the 2-way branch target buffer, sized for the
// default configuration (32 sets, 2-bit counters, 32-bit PCs).
package btb_pkg;

  localparam int BTB_SETS  = 32;
  localparam int BTB_CNT_W = 2;
  localparam int BTB_PC_W  = 32;
  localparam int BTB_IDX_W = $clog2(BTB_SETS);
  localparam int BTB_TAG_W = BTB_PC_W - BTB_IDX_W - 2;

  // Fresh allocations start weakly taken.
  localparam logic [BTB_CNT_W-1:0] BTB_CNT_INIT = BTB_CNT_W'(1) << (BTB_CNT_W - 1);

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_PC_W-1:0]  target;
    logic [BTB_CNT_W-1:0] cnt;
  } btb_entry_t;

  function automatic logic [BTB_IDX_W-1:0] btb_index(input logic [BTB_PC_W-1:0] pc);
    return BTB_IDX_W'(pc >> 2);
  endfunction

  function automatic logic [BTB_TAG_W-1:0] btb_tag(input logic [BTB_PC_W-1:0] pc);
    return BTB_TAG_W'(pc >> (BTB_IDX_W + 2));
  endfunction

endpackage

// File: rtl/btb_sat_cnt.sv
// Saturating up/down direction counter: next value from current value.
module btb_sat_cnt #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (inc_i && (cnt_i != '1)) begin
      cnt_o = cnt_i + 1'b1;
    end else if (dec_i && (cnt_i != '0)) begin
      cnt_o = cnt_i - 1'b1;
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// 2-way set-associative BTB with saturating counters, LRU victim bit and flush.
// Optional perf counters are enabled by defining BTB_PERF_CNT_EN.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int SETS  = BTB_SETS,
  parameter int CNT_W = BTB_CNT_W,
  parameter int PC_W  = BTB_PC_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            lookup_valid_i,
  input  logic [PC_W-1:0] pc_if_i,
  output logic            hit_o,
  output logic [PC_W-1:0] predicted_pc_o,
  input  logic            res_valid_i,
  input  logic [PC_W-1:0] res_pc_i,
  input  logic            res_taken_i,
  input  logic [PC_W-1:0] res_target_i,
  input  logic            res_pred_taken_i,
  input  logic [PC_W-1:0] res_pred_target_i,
  output logic            mispredict_o,
  output logic [PC_W-1:0] redirect_pc_o,
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     mispred_cnt_o
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(1) << (CNT_W - 1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  entry_t            tbl_q [2][SETS];
  entry_t            tbl_d [2][SETS];
  logic [SETS-1:0]   lru_q, lru_d;

  logic [IDX_W-1:0]  lk_idx, rs_idx;
  logic [TAG_W-1:0]  lk_tag, rs_tag;
  logic [1:0]        lk_hit, rs_hit;
  logic              lk_way, rs_way, alloc_way;
  logic [CNT_W-1:0]  rs_cnt, rs_cnt_nxt;
  logic              unused_pc_lsb;

  assign lk_idx = pc_if_i[IDX_W+1:2];
  assign lk_tag = pc_if_i[PC_W-1:IDX_W+2];
  assign rs_idx = res_pc_i[IDX_W+1:2];
  assign rs_tag = res_pc_i[PC_W-1:IDX_W+2];
  assign unused_pc_lsb = ^pc_if_i[1:0];

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      lk_hit[w] = tbl_q[w][lk_idx].valid && (tbl_q[w][lk_idx].tag == lk_tag);
      rs_hit[w] = tbl_q[w][rs_idx].valid && (tbl_q[w][rs_idx].tag == rs_tag);
    end
  end

  // Way 0 takes precedence when both ways carry the same tag.
  assign lk_way = ~lk_hit[0];
  assign rs_way = ~rs_hit[0];
  assign rs_cnt = tbl_q[rs_way][rs_idx].cnt;

  assign hit_o          = lookup_valid_i & (|lk_hit) & tbl_q[lk_way][lk_idx].cnt[CNT_W-1];
  assign predicted_pc_o = hit_o ? tbl_q[lk_way][lk_idx].target : '0;

  assign mispredict_o  = res_valid_i &
                         ((res_taken_i != res_pred_taken_i) |
                          (res_taken_i & (res_pred_target_i != res_target_i)));
  assign redirect_pc_o = !mispredict_o ? '0 :
                         res_taken_i   ? res_target_i : res_pc_i + PC_W'(4);

  assign alloc_way = !tbl_q[0][rs_idx].valid ? 1'b0 :
                     !tbl_q[1][rs_idx].valid ? 1'b1 : lru_q[rs_idx];

  btb_sat_cnt #(.CNT_W(CNT_W)) u_sat_cnt (
    .cnt_i (rs_cnt),
    .inc_i (res_taken_i),
    .dec_i (~res_taken_i),
    .cnt_o (rs_cnt_nxt)
  );

  always_comb begin
    tbl_d = tbl_q;
    lru_d = lru_q;
    if (flush_i) begin
      for (int w = 0; w < 2; w++) begin
        for (int s = 0; s < SETS; s++) begin
          tbl_d[w][s].valid = 1'b0;
        end
      end
      lru_d = '0;
    end else if (res_valid_i) begin
      if (|rs_hit) begin
        tbl_d[rs_way][rs_idx].cnt = rs_cnt_nxt;
        if (res_taken_i) begin
          tbl_d[rs_way][rs_idx].target = res_target_i;
        end
        lru_d[rs_idx] = ~rs_way;
      end else if (res_taken_i) begin
        tbl_d[alloc_way][rs_idx].valid  = 1'b1;
        tbl_d[alloc_way][rs_idx].tag    = rs_tag;
        tbl_d[alloc_way][rs_idx].target = res_target_i;
        tbl_d[alloc_way][rs_idx].cnt    = CNT_INIT;
        lru_d[rs_idx] = ~alloc_way;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tbl_q <= '{default: '0};
      lru_q <= '0;
    end else begin
      tbl_q <= tbl_d;
      lru_q <= lru_d;
    end
  end

`ifdef BTB_PERF_CNT_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (res_valid_i && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (mispredict_o && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  // Flush leaves the counters alone; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;
`else
  assign branch_cnt_o  = '0;
  assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc: directed vector table, hand-written
// corner sequences, then random traffic against a behavioural model.
module tb_btb_assoc;

  localparam int SETS  = 32;
  localparam int CNT_W = 2;
  localparam int PC_W  = 32;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int CNT_TAKEN = 1 << (CNT_W - 1);

  logic        clk = 1'b0;
  logic        rst, flush, lv, rv, rt, rpt;
  logic [31:0] pc_if, rpc, rtgt, rptgt;
  logic        hit, mis;
  logic [31:0] ppc, redir, bcnt, mcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btb_assoc #(.SETS(SETS), .CNT_W(CNT_W), .PC_W(PC_W)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .flush_i           (flush),
    .lookup_valid_i    (lv),
    .pc_if_i           (pc_if),
    .hit_o             (hit),
    .predicted_pc_o    (ppc),
    .res_valid_i       (rv),
    .res_pc_i          (rpc),
    .res_taken_i       (rt),
    .res_target_i      (rtgt),
    .res_pred_taken_i  (rpt),
    .res_pred_target_i (rptgt),
    .mispredict_o      (mis),
    .redirect_pc_o     (redir),
    .branch_cnt_o      (bcnt),
    .mispred_cnt_o     (mcnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; lv = 0; pc_if = 0;
    rv = 0; rpc = 0; rt = 0; rtgt = 0; rpt = 0; rptgt = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic resolve(input logic [31:0] pc, input bit t, input logic [31:0] tg,
                         input bit pt, input logic [31:0] ptg);
    rv = 1; rpc = pc; rt = t; rtgt = tg; rpt = pt; rptgt = ptg;
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_v   [2][SETS];
  logic [31:0] m_tag [2][SETS];
  logic [31:0] m_tgt [2][SETS];
  int          m_cnt [2][SETS];
  int          m_vict[SETS];
  longint      m_b, m_m;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % SETS);
  endfunction

  function automatic logic [31:0] m_tg(input logic [31:0] pc);
    return pc / (4 * SETS);
  endfunction

  function automatic int m_find(input logic [31:0] pc);
    for (int w = 0; w < 2; w++)
      if (m_v[w][m_idx(pc)] && m_tag[w][m_idx(pc)] == m_tg(pc)) return w;
    return -1;
  endfunction

  task automatic m_clear();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < SETS; s++) begin
        m_v[w][s] = 0; m_tag[w][s] = 0; m_tgt[w][s] = 0; m_cnt[w][s] = 0;
      end
    for (int s = 0; s < SETS; s++) m_vict[s] = 0;
    m_b = 0; m_m = 0;
  endtask

  task automatic m_edge(input bit r, input bit f, input bit v, input logic [31:0] pc,
                        input bit t, input logic [31:0] tg, input bit mp);
    int w, i;
    if (r) begin
      m_clear();
      return;
    end
    if (v) begin
      if (m_b < 64'hFFFF_FFFF) m_b++;
      if (mp && m_m < 64'hFFFF_FFFF) m_m++;
    end
    if (f) begin
      for (int ww = 0; ww < 2; ww++)
        for (int s = 0; s < SETS; s++) m_v[ww][s] = 0;
      for (int s = 0; s < SETS; s++) m_vict[s] = 0;
    end else if (v) begin
      i = m_idx(pc);
      w = m_find(pc);
      if (w >= 0) begin
        if (t) begin
          if (m_cnt[w][i] < CNT_MAX) m_cnt[w][i]++;
          m_tgt[w][i] = tg;
        end else if (m_cnt[w][i] > 0) m_cnt[w][i]--;
        m_vict[i] = 1 - w;
      end else if (t) begin
        if (!m_v[0][i]) w = 0;
        else if (!m_v[1][i]) w = 1;
        else w = m_vict[i];
        m_v[w][i] = 1; m_tag[w][i] = m_tg(pc); m_tgt[w][i] = tg; m_cnt[w][i] = CNT_TAKEN;
        m_vict[i] = 1 - w;
      end
    end
  endtask

  function automatic logic [31:0] rnd_pc();
    if ($urandom_range(0, 15) == 0) return $urandom;
    return ($urandom_range(0, 3) << 7) | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
  endfunction

  function automatic logic [31:0] rnd_tgt();
    case ($urandom_range(0, 3))
      0: return 32'h400;
      1: return 32'h404;
      2: return 32'h800;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rv;
    logic [31:0] rpc;
    bit          rt;
    logic [31:0] rtgt;
    bit          rpt;
    logic [31:0] rptgt;
    logic [31:0] lpc;
    bit          e_hit;
    logic [31:0] e_ppc;
    bit          e_mis;
    logic [31:0] e_red;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit v, logic [31:0] p, bit t, logic [31:0] tg, bit pt,
                              logic [31:0] ptg, logic [31:0] l, bit eh, logic [31:0] ep,
                              bit em, logic [31:0] er);
    vec_t x;
    x.rv = v; x.rpc = p; x.rt = t; x.rtgt = tg; x.rpt = pt; x.rptgt = ptg;
    x.lpc = l; x.e_hit = eh; x.e_ppc = ep; x.e_mis = em; x.e_red = er;
    return x;
  endfunction

  initial begin
    bit          e_hit, e_mis;
    logic [31:0] e_ppc, e_red, exp_b, exp_m;
    int          w;

    // Lookup in each row sees the table as it was before that row's resolve.
    vt.push_back(mk(0, 0,     0, 0,     0, 0,     'h100, 0, 0,     0, 0));
    vt.push_back(mk(1, 'h100, 1, 'h200, 0, 0,     'h100, 0, 0,     1, 'h200));
    vt.push_back(mk(0, 0,     0, 0,     0, 0,     'h100, 1, 'h200, 0, 0));
    vt.push_back(mk(1, 'h100, 0, 0,     1, 'h200, 'h100, 1, 'h200, 1, 'h104));
    vt.push_back(mk(0, 0,     0, 0,     0, 0,     'h100, 0, 0,     0, 0));
    vt.push_back(mk(1, 'h100, 1, 'h300, 0, 0,     'h100, 0, 0,     1, 'h300));
    vt.push_back(mk(1, 'h180, 1, 'h340, 0, 0,     'h100, 1, 'h300, 1, 'h340));
    vt.push_back(mk(1, 'h200, 1, 'h380, 0, 0,     'h180, 1, 'h340, 1, 'h380));
    vt.push_back(mk(0, 0,     0, 0,     0, 0,     'h180, 1, 'h340, 0, 0));
    vt.push_back(mk(0, 0,     0, 0,     0, 0,     'h200, 1, 'h380, 0, 0));
    vt.push_back(mk(0, 0,     0, 0,     0, 0,     'h100, 0, 0,     0, 0));
    vt.push_back(mk(1, 'h180, 1, 'h340, 1, 'h340, 'h200, 1, 'h380, 0, 0));
    vt.push_back(mk(1, 'h200, 0, 0,     0, 0,     'h180, 1, 'h340, 0, 0));
    vt.push_back(mk(0, 0,     0, 0,     0, 0,     'h200, 0, 0,     0, 0));
    vt.push_back(mk(1, 'h180, 1, 'h344, 1, 'h340, 'h180, 1, 'h340, 1, 'h344));
    vt.push_back(mk(0, 0,     0, 0,     0, 0,     'h180, 1, 'h344, 0, 0));

    do_reset();
    #1;
    chk("rst_hit", 32'(hit), 0);
    chk("rst_ppc", ppc, 0);
    chk("rst_mis", 32'(mis), 0);
    chk("rst_redir", redir, 0);
    chk("rst_bcnt", bcnt, 0);
    chk("rst_mcnt", mcnt, 0);

    foreach (vt[k]) begin
      lv = 1; pc_if = vt[k].lpc;
      rv = vt[k].rv; rpc = vt[k].rpc; rt = vt[k].rt; rtgt = vt[k].rtgt;
      rpt = vt[k].rpt; rptgt = vt[k].rptgt;
      #1;
      chk($sformatf("vec%0d_hit", k), 32'(hit), 32'(vt[k].e_hit));
      chk($sformatf("vec%0d_ppc", k), ppc, vt[k].e_ppc);
      chk($sformatf("vec%0d_mis", k), 32'(mis), 32'(vt[k].e_mis));
      chk($sformatf("vec%0d_redir", k), redir, vt[k].e_red);
      tick();
    end

    // Flush in the same cycle as a taken resolve: flush wins.
    do_reset();
    resolve('h100, 1, 'h200, 0, 0);
    tick();
    flush = 1; lv = 1; pc_if = 'h100;
    resolve('h180, 1, 'h340, 0, 0);
    #1;
    chk("flush_cycle_hit", 32'(hit), 1);
    chk("flush_cycle_ppc", ppc, 'h200);
    chk("flush_cycle_mis", 32'(mis), 1);
    tick();
    idle(); lv = 1; pc_if = 'h100;
    #1;
    chk("flush_miss_100", 32'(hit), 0);
    pc_if = 'h180;
    #1;
    chk("flush_miss_180", 32'(hit), 0);

    // Back-to-back updates of one entry; lookup sees pre-update contents.
    tick();
    resolve('h100, 1, 'h200, 0, 0);
    lv = 1; pc_if = 'h100;
    tick();
    resolve('h100, 1, 'h200, 1, 'h200);
    #1; chk("b2b_hit_cnt10", 32'(hit), 1);
    chk("b2b_mis_correct", 32'(mis), 0);
    tick();
    resolve('h100, 0, 0, 1, 'h200);
    #1; chk("b2b_hit_cnt11", 32'(hit), 1);
    tick();
    #1; chk("b2b_hit_cnt10b", 32'(hit), 1);
    tick();
    rv = 0;
    #1; chk("b2b_miss_cnt01", 32'(hit), 0);

    // A resolve during reset is dropped.
    resolve('h180, 1, 'h340, 0, 0);
    rst = 1;
    tick();
    idle(); lv = 1; pc_if = 'h180;
    #1;
    chk("rst_drop_180", 32'(hit), 0);
    pc_if = 'h100;
    #1;
    chk("rst_drop_100", 32'(hit), 0);

    // Ten resolves, three mispredicting.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      resolve(32'h1000 + 32'(i) * 4, 0, 0, (i % 3) == 2, 0);
      tick();
    end
    idle();
    #1;
`ifdef BTB_PERF_CNT_EN
    exp_b = 10; exp_m = 3;
`else
    exp_b = 0; exp_m = 0;
`endif
    chk("perf_branch", bcnt, exp_b);
    chk("perf_mispred", mcnt, exp_m);
    flush = 1;
    tick();
    flush = 0;
    #1;
    chk("perf_branch_after_flush", bcnt, exp_b);

    // Random traffic against the model.
    do_reset();
    m_clear();
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 39) == 0);
      lv    = ($urandom_range(0, 3) != 0);
      pc_if = rnd_pc();
      rv    = $urandom_range(0, 1);
      rpc   = rnd_pc();
      rt    = $urandom_range(0, 1);
      rtgt  = rnd_tgt();
      w     = m_find(rpc);
      if ($urandom_range(0, 1) == 0 && w >= 0) begin
        rpt   = (m_cnt[w][m_idx(rpc)] >= CNT_TAKEN);
        rptgt = rpt ? m_tgt[w][m_idx(rpc)] : 0;
      end else begin
        rpt   = $urandom_range(0, 1);
        rptgt = rnd_tgt();
      end
      #1;
      w     = m_find(pc_if);
      e_hit = lv && (w >= 0) && (m_cnt[w][m_idx(pc_if)] >= CNT_TAKEN);
      e_ppc = e_hit ? m_tgt[w][m_idx(pc_if)] : 0;
      e_mis = rv && ((rt != rpt) || (rt && rptgt != rtgt));
      e_red = !e_mis ? 0 : (rt ? rtgt : rpc + 4);
`ifdef BTB_PERF_CNT_EN
      exp_b = 32'(m_b); exp_m = 32'(m_m);
`else
      exp_b = 0; exp_m = 0;
`endif
      chk("rand_hit", 32'(hit), 32'(e_hit));
      chk("rand_ppc", ppc, e_ppc);
      chk("rand_mis", 32'(mis), 32'(e_mis));
      chk("rand_redir", redir, e_red);
      chk("rand_bcnt", bcnt, exp_b);
      chk("rand_mcnt", mcnt, exp_m);
      m_edge(rst, flush, rv, rpc, rt, rtgt, e_mis);
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised, 2-way set-associative branch target buffer with per-entry saturating direction counters, valid bits, LRU replacement and a flush port. Fetch-stage lookups are combinational. Branch resolutions arrive from MEM, are checked for misprediction in the same cycle, and update the table on the next clock edge. It is the next-generation replacement for the fetch-stage direct-mapped 2-bit predictor.

## Interface
- SETS, 32, number of sets; power of 2, ≥2; index = pc[log2(SETS)+1:2]
- CNT_W, 2, direction counter width; ≥1
- PC_W, 32, PC/target width; tag = pc[PC_W-1:log2(SETS)+2]
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-high
- flush_i  in  1  invalidate all entries (e.g. fence.i)
- lookup_valid_i  in  1  branch/jump present in IF
- pc_if_i  in  PC_W  IF-stage PC
- hit_o  out  1  predict taken
- predicted_pc_o  out  PC_W  predicted target; 0 when hit_o=0
- res_valid_i  in  1  a branch resolves in MEM this cycle
- res_pc_i  in  PC_W  PC of the resolving branch
- res_taken_i  in  1  actual direction
- res_target_i  in  PC_W  actual target (ALU result)
- res_pred_taken_i  in  1  hit_o carried down the pipeline with this branch
- res_pred_target_i  in  PC_W  predicted_pc_o carried down the pipeline
- mispredict_o  out  1  redirect the front end
- redirect_pc_o  out  PC_W  correct next PC; 0 when mispredict_o=0
- branch_cnt_o  out  32  resolved branches (see Configuration)
- mispred_cnt_o  out  32  mispredictions (see Configuration)

## Operation
- Entry: valid, tag, target, counter[CNT_W]. Per set: one LRU bit naming the victim way.
- Lookup: a way hits when valid and its tag matches. If both ways match, way 0 wins. hit_o = lookup_valid_i & way hit & counter MSB. predicted_pc_o = that way's target, else 0.
- Mispredict: res_valid_i & ((res_taken_i≠res_pred_taken_i) | (res_taken_i & res_pred_target_i≠res_target_i)).
- Redirect: redirect_pc_o = res_taken_i ? res_target_i : res_pc_i+4 (modulo 2^PC_W).
- Update on res_valid_i, resolve-side hit:
  - taken: counter +1, saturating at all-ones; target ← res_target_i.
  - not taken: counter −1, saturating at 0; target kept.
- Update on res_valid_i, resolve-side miss:
  - taken: allocate into the first invalid way (way 0 first), else the LRU way. Set valid=1, tag, target, counter = 1<<(CNT_W-1) (weakly taken).
  - not taken: no allocation, no LRU change.
- LRU: every resolve hit or allocation sets the set's LRU to the other way. Lookups never touch LRU.
- Priority: rst_i > flush_i > resolve update.
  - rst_i clears valid, tag, target, counter and LRU everywhere.
  - flush_i clears valid and LRU only.
  - Combinational outputs still reflect current state during rst_i/flush_i cycles.

## Timing
- Lookup → hit_o/predicted_pc_o: combinational, 0 cycles.
- res_* → mispredict_o/redirect_pc_o: combinational, 0 cycles.
- Table update is visible to lookups from the cycle after res_valid_i. There is no same-cycle bypass: a lookup to the entry being written sees the old contents.
- Back-to-back resolves to the same entry, one per cycle: each cycle's update sees the previous cycle's result.
- Reset values: hit_o=0, predicted_pc_o=0, mispredict_o=0, redirect_pc_o=0 while inputs are idle; branch_cnt_o=0, mispred_cnt_o=0. State is cleared from the first edge with rst_i=1. A resolve in that cycle is dropped.

## Configuration
- BTB_PERF_CNT_EN defined:
  - branch_cnt_o increments on each res_valid_i.
  - mispred_cnt_o increments on each mispredict_o.
  - Both saturate at 0xFFFF_FFFF and clear on rst_i (not on flush_i).
- BTB_PERF_CNT_EN undefined: both ports tied to 0, no counter flops.

## Structure
- Package btb_pkg:
  - entry struct typedef.
  - functions btb_index(pc) and btb_tag(pc), derived from SETS/PC_W.
  - counter-init constant.
- Sub-module btb_sat_cnt (CNT_W parameter; inc/dec inputs, saturating next-value output), instantiated per update path.

## Test plan
Defaults SETS=32, CNT_W=2; 0x100, 0x180 and 0x200 all map to index 0.
- After reset, lookup 0x100 → hit_o=0, predicted_pc_o=0.
- Resolve 0x100, taken, target 0x200, pred_taken=0 → mispredict_o=1, redirect 0x200. Next cycle, lookup 0x100 → hit_o=1, predicted_pc_o=0x200 (counter 10).
- Then resolve 0x100, not taken, pred_taken=1, pred_target=0x200 → mispredict_o=1, redirect 0x104. Next cycle, lookup 0x100 → hit_o=0 (counter 01).
- Resolve taken, in order: 0x100→0x300, 0x180→0x340, 0x200→0x380 → 0x100 evicted. Lookups: 0x180 hits (0x340), 0x200 hits (0x380), 0x100 misses.
- Populate 0x100. Then flush_i=1 in the same cycle as a taken resolve of 0x180 → next cycle both 0x100 and 0x180 miss.
- 10 resolves, 3 mispredicting → branch_cnt_o=10, mispred_cnt_o=3 with BTB_PERF_CNT_EN defined; both stay 0 when it is undefined.
